// File: rtl/axi_lite_master_arbiter_if.sv
// AXI4-Lite single-master bus bundle: AW, W, B, AR and R channels.
// The master modport is the arbiter side, the slave modport the SoC side.
interface axi_lite_master_arbiter_if;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;

  modport master (
    output m_awaddr, m_awvalid, input m_awready,
    output m_wdata, m_wstrb, m_wvalid, input m_wready,
    input  m_bresp, m_bvalid, output m_bready,
    output m_araddr, m_arvalid, input m_arready,
    input  m_rdata, m_rresp, m_rvalid, output m_rready
  );

  modport slave (
    input  m_awaddr, m_awvalid, output m_awready,
    input  m_wdata, m_wstrb, m_wvalid, output m_wready,
    output m_bresp, m_bvalid, input m_bready,
    input  m_araddr, m_arvalid, output m_arready,
    output m_rdata, m_rresp, m_rvalid, input m_rready
  );
endinterface

// File: rtl/axi_lite_master_arbiter.sv
// Two-requester AXI4-Lite master: arbitrates the data (load/store) port and
// the fetch read port onto one AXI4-Lite bus, one single-beat transaction at
// a time, and returns read data. Busy outputs are the pipeline stall sources.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin between data and fetch on
// contention; default build uses fixed priority (data over fetch).
module axi_lite_master_arbiter (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              d_write_start,
  input  logic [31:0]                       d_write_addr,
  input  logic [31:0]                       d_write_data,
  input  logic [3:0]                        d_write_strobe,
  output logic                              d_write_busy,
  input  logic                              d_read_start,
  input  logic [31:0]                       d_read_addr,
  output logic [31:0]                       d_read_data,
  output logic                              d_read_busy,
  input  logic                              f_read_start,
  input  logic [31:0]                       f_read_addr,
  output logic [31:0]                       f_read_data,
  output logic                              f_read_busy,
  axi_lite_master_arbiter_if.master         m,
  output logic                              bus_error
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

  state_t state;
  logic   grant_fetch;   // 0: data port owns the bus, 1: fetch port
  logic   d_req;
  logic   pick_fetch;

  assign d_req = d_write_start || d_read_start;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_fetch;      // last grant went to fetch; resets to fetch so data wins first

  // Round-robin choice: on contention serve the port not granted last.
  always_comb begin
    pick_fetch = !d_req;
    if (d_req && f_read_start) pick_fetch = !last_fetch;
  end
`else
  // Fixed priority: fetch only when the data port is idle.
  assign pick_fetch = !d_req;
`endif

  // Busy stays high until the DONE cycle of this port's own grant.
  assign d_write_busy = d_write_start && !(state == DONE && !grant_fetch);
  assign d_read_busy  = d_read_start  && !(state == DONE && !grant_fetch);
  assign f_read_busy  = f_read_start  && !(state == DONE &&  grant_fetch);

  // Transaction sequencer with registered bus outputs and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant_fetch <= 1'b0;
      m.m_awaddr  <= '0;
      m.m_awvalid <= 1'b0;
      m.m_wdata   <= '0;
      m.m_wstrb   <= '0;
      m.m_wvalid  <= 1'b0;
      m.m_bready  <= 1'b0;
      m.m_araddr  <= '0;
      m.m_arvalid <= 1'b0;
      m.m_rready  <= 1'b0;
      d_read_data <= '0;
      f_read_data <= '0;
      bus_error   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_fetch  <= 1'b1;
`endif
    end else begin
      bus_error <= 1'b0;
      case (state)
        IDLE: begin
          if (d_req || f_read_start) begin
            grant_fetch <= pick_fetch;
`ifdef ARB_ROUND_ROBIN_EN
            last_fetch  <= pick_fetch;
`endif
            if (pick_fetch) begin
              m.m_araddr  <= f_read_addr;
              m.m_arvalid <= 1'b1;
              state       <= RD_REQ;
            end else if (d_write_start) begin
              // A simultaneous data read is illegal; the store wins.
              m.m_awaddr  <= d_write_addr;
              m.m_wdata   <= d_write_data;
              m.m_wstrb   <= d_write_strobe;
              m.m_awvalid <= 1'b1;
              m.m_wvalid  <= 1'b1;
              state       <= WR_REQ;
            end else begin
              m.m_araddr  <= d_read_addr;
              m.m_arvalid <= 1'b1;
              state       <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          // AW and W complete independently, in any order.
          if (m.m_awready) m.m_awvalid <= 1'b0;
          if (m.m_wready)  m.m_wvalid  <= 1'b0;
          if ((!m.m_awvalid || m.m_awready) && (!m.m_wvalid || m.m_wready)) begin
            m.m_bready <= 1'b1;
            state      <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m.m_bvalid) begin
            m.m_bready <= 1'b0;
            bus_error  <= (m.m_bresp != 2'b00);
            state      <= DONE;
          end
        end
        RD_REQ: begin
          if (m.m_arready) begin
            m.m_arvalid <= 1'b0;
            m.m_rready  <= 1'b1;
            state       <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (m.m_rvalid) begin
            // Data is captured even on error or after a flush.
            m.m_rready <= 1'b0;
            bus_error  <= (m.m_rresp != 2'b00);
            if (grant_fetch) f_read_data <= m.m_rdata;
            else             d_read_data <= m.m_rdata;
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// Directed bench for axi_lite_master_arbiter: vector table of single
// transactions against a wait-state-configurable slave model, plus hand
// sequences for contention, flush and mid-transaction reset.
module tb_axi_lite_master_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_write_start, d_read_start, f_read_start;
  logic [31:0] d_write_addr, d_write_data, d_read_addr, f_read_addr;
  logic [3:0]  d_write_strobe;
  logic        d_write_busy, d_read_busy, f_read_busy, bus_error;
  logic [31:0] d_read_data, f_read_data;

  axi_lite_master_arbiter_if bus ();

  axi_lite_master_arbiter dut (
    .clk(clk), .rst(rst),
    .d_write_start(d_write_start), .d_write_addr(d_write_addr),
    .d_write_data(d_write_data), .d_write_strobe(d_write_strobe),
    .d_write_busy(d_write_busy),
    .d_read_start(d_read_start), .d_read_addr(d_read_addr),
    .d_read_data(d_read_data), .d_read_busy(d_read_busy),
    .f_read_start(f_read_start), .f_read_addr(f_read_addr),
    .f_read_data(f_read_data), .f_read_busy(f_read_busy),
    .m(bus.master), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  // Slave configuration (written by the test) and observation logs.
  int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;
  int          aw_hs = 0, w_hs = 0, ar_hs = 0;
  logic [31:0] aw_last_addr = 0, w_last_data = 0;
  logic [3:0]  w_last_strb = 0;
  logic [31:0] ar_log [64];

  // Slave model: drives ready/valid at the falling edge after the configured
  // number of wait cycles, and logs each handshake that the next rising edge
  // will complete.
  initial begin
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0; bus.m_bresp = 0;
    bus.m_arready = 0; bus.m_rvalid = 0; bus.m_rresp = 0; bus.m_rdata = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0;
        bus.m_arready = 0; bus.m_rvalid = 0;
      end else begin
        bus.m_awready = bus.m_awvalid && (aw_cnt == aw_wait);
        if (bus.m_awready) begin
          aw_cnt = 0; aw_hs++; aw_last_addr = bus.m_awaddr;
        end else if (bus.m_awvalid) aw_cnt++;
        bus.m_wready = bus.m_wvalid && (w_cnt == w_wait);
        if (bus.m_wready) begin
          w_cnt = 0; w_hs++; w_last_data = bus.m_wdata; w_last_strb = bus.m_wstrb;
        end else if (bus.m_wvalid) w_cnt++;
        bus.m_bvalid = bus.m_bready && (b_cnt == b_wait);
        bus.m_bresp  = bresp_cfg;
        if (bus.m_bvalid) b_cnt = 0;
        else if (bus.m_bready) b_cnt++;
        bus.m_arready = bus.m_arvalid && (ar_cnt == ar_wait);
        if (bus.m_arready) begin
          ar_cnt = 0; ar_log[ar_hs % 64] = bus.m_araddr; ar_hs++;
        end else if (bus.m_arvalid) ar_cnt++;
        bus.m_rvalid = bus.m_rready && (r_cnt == r_wait);
        bus.m_rdata  = rdata_cfg;
        bus.m_rresp  = rresp_cfg;
        if (bus.m_rvalid) r_cnt = 0;
        else if (bus.m_rready) r_cnt++;
      end
    end
  end

  int n_checks = 0, n_fail = 0;
  logic [31:0] exp_d = 0, exp_f = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        fetch;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          aw_w;
    int          w_w;
    int          ar_w;
    int          rsp_w;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  function automatic logic cur_busy(input vec_t v);
    if (v.wr) return d_write_busy;
    if (v.fetch) return f_read_busy;
    return d_read_busy;
  endfunction

  // One transaction from a table row; cycle 0 is the cycle the request is first seen.
  task automatic run_vec(input vec_t v, input int idx);
    int done_k, aw0, w0, ar0;
    string tag;
    tag = $sformatf("v%0d", idx);
    aw_wait = v.aw_w; w_wait = v.w_w; ar_wait = v.ar_w;
    b_wait = v.rsp_w; r_wait = v.rsp_w;
    bresp_cfg = v.resp; rresp_cfg = v.resp; rdata_cfg = v.rdata;
    aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs;
    @(negedge clk); #1;
    if (v.wr) begin
      d_write_start = 1; d_write_addr = v.addr; d_write_data = v.wdata; d_write_strobe = v.strb;
    end else if (v.fetch) begin
      f_read_start = 1; f_read_addr = v.addr;
    end else begin
      d_read_start = 1; d_read_addr = v.addr;
    end
    #1 chk({tag, "_busy_c0"}, 32'(cur_busy(v)), 32'd1);
    done_k = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk); #1;
      if (!cur_busy(v)) begin done_k = k; break; end
    end
    chk({tag, "_done_cycle"}, 32'(done_k), 32'(v.exp_done));
    chk({tag, "_bus_error_done"}, 32'(bus_error), 32'(v.exp_err));
    if (!v.wr) begin
      if (v.fetch) exp_f = v.rdata; else exp_d = v.rdata;
      chk({tag, "_ar_count"}, 32'(ar_hs - ar0), 32'd1);
      chk({tag, "_araddr"}, ar_log[(ar_hs + 63) % 64], v.addr);
    end else begin
      chk({tag, "_aw_count"}, 32'(aw_hs - aw0), 32'd1);
      chk({tag, "_w_count"}, 32'(w_hs - w0), 32'd1);
      chk({tag, "_awaddr"}, aw_last_addr, v.addr);
      chk({tag, "_wdata"}, w_last_data, v.wdata);
      chk({tag, "_wstrb"}, 32'(w_last_strb), 32'(v.strb));
    end
    chk({tag, "_d_read_data"}, d_read_data, exp_d);
    chk({tag, "_f_read_data"}, f_read_data, exp_f);
    d_write_start = 0; d_read_start = 0; f_read_start = 0;
    @(negedge clk); #1;
    chk({tag, "_bus_error_after"}, 32'(bus_error), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h100,  32'h0,        4'h0,    0, 0, 0, 0, 2'b00, 32'hDEADBEEF, 3, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h2004, 32'h11223344, 4'b0011, 2, 0, 0, 0, 2'b00, 32'h0,        5, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'h3000, 32'h0,        4'h0,    0, 0, 0, 0, 2'b10, 32'h55,       3, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 32'h3010, 32'h0,        4'h0,    0, 0, 1, 2, 2'b00, 32'hCAFEF00D, 6, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h4008, 32'hA5A5A5A5, 4'b1100, 1, 3, 0, 1, 2'b11, 32'h0,        7, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 32'h0104, 32'h0,        4'h0,    0, 0, 0, 1, 2'b00, 32'h01020304, 4, 1'b0};

    rst = 1;
    d_write_start = 1; d_read_start = 0; f_read_start = 0;
    d_write_addr = 0; d_write_data = 0; d_write_strobe = 0; d_read_addr = 0; f_read_addr = 0;
    #2;
    chk("rst_d_write_busy", 32'(d_write_busy), 32'd1);
    chk("rst_valids", {28'b0, bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus_error}, 32'd0);
    chk("rst_readies", {30'b0, bus.m_bready, bus.m_rready}, 32'd0);
    chk("rst_awaddr", bus.m_awaddr, 32'd0);
    chk("rst_araddr", bus.m_araddr, 32'd0);
    chk("rst_wdata_wstrb", bus.m_wdata | 32'(bus.m_wstrb), 32'd0);
    chk("rst_read_data", d_read_data | f_read_data, 32'd0);
    d_write_start = 0;
    @(negedge clk); @(negedge clk); #1 rst = 0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Contention: data and fetch reads held across two zero-wait transactions.
    begin
      int ar0;
      logic exp_fb, exp_db;
      aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0; b_wait = 0;
      rresp_cfg = 2'b00; rdata_cfg = 32'h11112222;
      ar0 = ar_hs;
      @(negedge clk); #1;
      d_read_start = 1; d_read_addr = 32'h300; f_read_start = 1; f_read_addr = 32'h400;
      for (int k = 0; k <= 7; k++) begin
        if (k > 0) begin @(negedge clk); #1; end
        #1;
`ifdef ARB_ROUND_ROBIN_EN
        exp_fb = (k != 7);
        exp_db = (k != 3);
`else
        exp_fb = 1'b1;
        exp_db = (k != 3) && (k != 7);
`endif
        chk($sformatf("cont_f_busy_c%0d", k), 32'(f_read_busy), 32'(exp_fb));
        chk($sformatf("cont_d_busy_c%0d", k), 32'(d_read_busy), 32'(exp_db));
      end
      d_read_start = 0; f_read_start = 0;
      chk("cont_ar_count", 32'(ar_hs - ar0), 32'd2);
      chk("cont_first_addr", ar_log[ar0 % 64], 32'h300);
      exp_d = 32'h11112222;
`ifdef ARB_ROUND_ROBIN_EN
      chk("cont_second_addr", ar_log[(ar0 + 1) % 64], 32'h400);
      exp_f = 32'h11112222;
`else
      chk("cont_second_addr", ar_log[(ar0 + 1) % 64], 32'h300);
`endif
      chk("cont_d_read_data", d_read_data, exp_d);
      chk("cont_f_read_data", f_read_data, exp_f);
    end

    // Flush: data read dropped in RD_RESP with rvalid delayed 4 cycles.
    begin
      int done_k;
      r_wait = 4; rdata_cfg = 32'h00005A5A;
      @(negedge clk); @(negedge clk); #1;
      d_read_start = 1; d_read_addr = 32'h500;
      @(negedge clk); #1;
      #1 chk("flush_busy_c1", 32'(d_read_busy), 32'd1);
      for (int k = 2; k <= 7; k++) begin
        @(negedge clk); #1;
        if (k == 2) d_read_start = 0;
        #1 chk($sformatf("flush_busy_c%0d", k), 32'(d_read_busy), 32'd0);
        if (k == 6) begin f_read_start = 1; f_read_addr = 32'h600; end
      end
      chk("flush_d_read_data", d_read_data, 32'h00005A5A);
      exp_d = 32'h00005A5A;
      r_wait = 0; rdata_cfg = 32'h00006060;
      @(negedge clk); #1;
      chk("flush_next_pending", 32'(f_read_busy), 32'd1);
      @(negedge clk); #1;
      chk("flush_next_arvalid", 32'(bus.m_arvalid), 32'd1);
      chk("flush_next_araddr", bus.m_araddr, 32'h600);
      done_k = 0;
      for (int k = 10; k <= 40; k++) begin
        @(negedge clk); #1;
        if (!f_read_busy) begin done_k = k; break; end
      end
      chk("flush_next_done_cycle", 32'(done_k), 32'd11);
      chk("flush_next_f_data", f_read_data, 32'h00006060);
      exp_f = 32'h00006060;
      f_read_start = 0;
    end

    // Reset pulsed while arvalid is waiting for a slow arready.
    begin
      int done_k, ar0;
      ar_wait = 5; rdata_cfg = 32'h77770000;
      @(negedge clk); @(negedge clk); #1;
      ar0 = ar_hs;
      f_read_start = 1; f_read_addr = 32'h700;
      @(negedge clk); #1;
      chk("rstmid_arvalid_before", 32'(bus.m_arvalid), 32'd1);
      @(negedge clk); #1;
      rst = 1;
      #1;
      chk("rstmid_valids", {28'b0, bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_rready}, 32'd0);
      chk("rstmid_read_data", d_read_data | f_read_data, 32'd0);
      chk("rstmid_f_busy", 32'(f_read_busy), 32'd1);
      exp_d = 0; exp_f = 0;
      ar_wait = 0;
      @(negedge clk); #1 rst = 0;
      done_k = 0;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk); #1;
        if (!f_read_busy) begin done_k = k; break; end
      end
      chk("rstmid_fresh_done_cycle", 32'(done_k), 32'd3);
      chk("rstmid_fresh_ar_count", 32'(ar_hs - ar0), 32'd1);
      chk("rstmid_fresh_araddr", ar_log[ar0 % 64], 32'h700);
      chk("rstmid_fresh_f_data", f_read_data, 32'h77770000);
      chk("rstmid_d_data_held", d_read_data, 32'd0);
      f_read_start = 0;
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
